// File: rtl/run_extrema_pkg.sv
// Shared types for run_extrema: frame operation modes, FSM states, and the
// saturating step-count helper.
package run_extrema_pkg;

  // Operation applied to a frame, captured when the frame starts.
  typedef enum logic [1:0] {
    MODE_MAX  = 2'd0,
    MODE_MIN  = 2'd1,
    MODE_RISE = 2'd2,
    MODE_FALL = 2'd3
  } mode_e;

  // Frame-level control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Ceiling of the 4-bit step counter.
  localparam logic [3:0] STEP_MAX = 4'd15;

  // Increment that sticks at STEP_MAX instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == STEP_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/run_extrema_ucmp4.sv
// ucmp4: 4-bit unsigned magnitude compare, a against b.
module ucmp4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       gt_o,
  output logic       lt_o
);

  // Pure combinational compare; equality raises neither flag.
  always_comb begin
    gt_o = (a_i > b_i);
    lt_o = (a_i < b_i);
  end

endmodule

// File: rtl/run_extrema.sv
// run_extrema: collects FRAME_LEN samples per frame and reports the max/min
// value with its first index, or the count of rising/falling steps.
// Optional feature: define RUN_EXTREMA_ABORT_EN to add an abort input that
// cancels a running or completed-but-unread frame.
module run_extrema
  import run_extrema_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int WIDTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_idx,
  output logic             busy
`ifdef RUN_EXTREMA_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] acc_q, acc_d;       // running extremum, or previous sample in step modes
  logic [3:0] idx_q, idx_d;       // index of the current extremum candidate
  logic [3:0] step_q, step_d;
  logic [3:0] res_data_q, res_data_d;
  logic [3:0] res_idx_q, res_idx_d;

  logic abort_w;
  logic xfer;
  logic last;
  logic first;
  logic gt;
  logic lt;
  logic is_extremum;

`ifdef RUN_EXTREMA_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign xfer        = in_valid & in_ready;
  assign last        = (cnt_q == LAST_IDX);
  assign first       = (cnt_q == 4'd0);
  assign is_extremum = ~mode_q[1];

  // One comparator serves every mode: sample against accumulator/previous.
  ucmp4 u_cmp (
    .a_i  (in_data),
    .b_i  (acc_q),
    .gt_o (gt),
    .lt_o (lt)
  );

  // State register; reset discards any partial or pending frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; abort outranks transfer and handshake.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        in_ready = ~abort_w;
        if (abort_w)          state_d = ST_IDLE;
        else if (xfer && last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = ~abort_w;
        if (abort_w || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: mode capture, per-sample update, result capture.
  always_comb begin
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    step_d     = step_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;

    if (state_q == ST_IDLE && start) begin
      mode_d = mode_e'(mode);
      cnt_d  = 4'd0;
    end

    if (xfer) begin
      cnt_d = last ? 4'd0 : cnt_q + 4'd1;
      case (mode_q)
        MODE_MAX, MODE_MIN: begin
          // Strict compare keeps the earliest index on ties.
          if (first || (mode_q == MODE_MAX && gt) || (mode_q == MODE_MIN && lt)) begin
            acc_d = in_data;
            idx_d = cnt_q;
          end
        end
        default: begin
          if (first) step_d = 4'd0;
          else if ((mode_q == MODE_RISE && gt) || (mode_q == MODE_FALL && lt))
            step_d = sat_inc4(step_q);
          acc_d = in_data;
        end
      endcase
      // Latch the result on the final sample so it appears one cycle later.
      if (last) begin
        res_data_d = is_extremum ? acc_d : step_d;
        res_idx_d  = is_extremum ? idx_d : 4'd0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_MAX;
      cnt_q      <= 4'd0;
      acc_q      <= 4'd0;
      idx_q      <= 4'd0;
      step_q     <= 4'd0;
      res_data_q <= 4'd0;
      res_idx_q  <= 4'd0;
    end else begin
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      step_q     <= step_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
    end
  end

  assign out_data = res_data_q;
  assign out_idx  = res_idx_q;

endmodule

// File: tb/tb_run_extrema.sv
// Self-checking bench for run_extrema: directed frames, a frame-level result
// model, and a per-cycle result compare process.
module tb_run_extrema;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] out_idx;
  logic       busy;
`ifdef RUN_EXTREMA_ABORT_EN
  logic       abort;
`endif

  run_extrema #(.FRAME_LEN(N), .WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy)
`ifdef RUN_EXTREMA_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];     // {data, idx} per completed frame awaiting readout
  logic [3:0] vec[N];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame result from the rules: extremum value and first position, or a
  // count of strict steps between neighbours.
  function automatic logic [7:0] model(input int m, input logic [3:0] s[N]);
    int best;
    int bi;
    int cnt;
    if (m < 2) begin
      best = s[0];
      for (int i = 1; i < N; i++) begin
        if (m == 0 && int'(s[i]) > best) best = s[i];
        if (m == 1 && int'(s[i]) < best) best = s[i];
      end
      bi = -1;
      for (int i = 0; i < N; i++)
        if (bi < 0 && int'(s[i]) == best) bi = i;
      return {4'(best), 4'(bi)};
    end
    cnt = 0;
    for (int i = 1; i < N; i++) begin
      if (m == 2 && s[i] > s[i-1]) cnt++;
      if (m == 3 && s[i] < s[i-1]) cnt++;
    end
    if (cnt > 15) cnt = 15;
    return {4'(cnt), 4'd0};
  endfunction

  // Every cycle a result is offered it must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", 8'd1, 8'd0);
      else begin
        check("out_data", {4'd0, out_data}, {4'd0, exp_q[0][7:4]});
        check("out_idx", {4'd0, out_idx}, {4'd0, exp_q[0][3:0]});
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from vec; optional in_valid gaps (with stray start
  // pulses) and a hold in DONE with out_ready low and start pulsing.
  task automatic run_frame(input int m, input int gaps, input int hold);
    start = 1'b1;
    mode  = 2'(m);
    tick();
    start = 1'b0;
    mode  = 2'(m) ^ 2'd3;
    check("busy_after_start", {7'd0, busy}, 8'd1);
    for (int i = 0; i < N; i++) begin
      if (gaps != 0) begin
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("stall_busy", {7'd0, busy}, 8'd1);
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      #1;
      check("in_ready_accum", {7'd0, in_ready}, 8'd1);
      check("no_early_valid", {7'd0, out_valid}, 8'd0);
      if (i == N - 1) exp_q.push_back(model(m, vec));
      tick();
    end
    in_valid = 1'b0;
    check("latency_valid", {7'd0, out_valid}, 8'd1);
    check("done_in_ready", {7'd0, in_ready}, 8'd0);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      tick();
      check("hold_valid", {7'd0, out_valid}, 8'd1);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_busy", {7'd0, busy}, 8'd0);
    check("idle_valid", {7'd0, out_valid}, 8'd0);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; in_valid = 1'b0;
    in_data = 4'd0; out_ready = 1'b0;
`ifdef RUN_EXTREMA_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check("rst_in_ready", {7'd0, in_ready}, 8'd0);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_out_data", {4'd0, out_data}, 8'd0);
    check("rst_out_idx", {4'd0, out_idx}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_after_rst", {7'd0, busy}, 8'd0);

    // Hand-computed pins on the model itself.
    vec = '{4'd3, 4'd9, 4'd2, 4'd9, 4'd5, 4'd1, 4'd0, 4'd7};
    check("model_max", model(0, vec), 8'h91);
    check("model_min", model(1, vec), 8'h06);
    vec = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd1, 4'd5, 4'd6, 4'd0};
    check("model_rise", model(2, vec), 8'h40);
    check("model_fall", model(3, vec), 8'h20);
    vec = '{4'd7, 4'd2, 4'd5, 4'd2, 4'd8, 4'd9, 4'd2, 4'd3};
    check("model_min_tie", model(1, vec), 8'h21);

    // Max with a tied maximum, then the same frame held in DONE.
    vec = '{4'd3, 4'd9, 4'd2, 4'd9, 4'd5, 4'd1, 4'd0, 4'd7};
    run_frame(0, 0, 0);
    run_frame(0, 0, 10);
    // Same stream with in_valid gaps must give the same result.
    run_frame(0, 1, 0);
    run_frame(1, 1, 0);

    vec = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
    run_frame(1, 0, 0);
    vec = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd1, 4'd5, 4'd6, 4'd0};
    run_frame(2, 0, 0);
    run_frame(3, 0, 2);
    vec = '{4'd7, 4'd2, 4'd5, 4'd2, 4'd8, 4'd9, 4'd2, 4'd3};
    run_frame(1, 0, 0);
    run_frame(0, 1, 0);

    // Asynchronous reset mid-frame after five samples.
    start = 1'b1; mode = 2'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 6);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", {7'd0, busy}, 8'd0);
    check("async_rst_in_ready", {7'd0, in_ready}, 8'd0);
    check("async_rst_out_data", {4'd0, out_data}, 8'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    vec = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    run_frame(0, 0, 0);

`ifdef RUN_EXTREMA_ABORT_EN
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_in_ready", {7'd0, in_ready}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_no_valid", {7'd0, out_valid}, 8'd0);
    end
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
